// File: rtl/emsensor_array.sv
// emsensor_array
// Array of EM fault-injection sensor cells with alarm aggregation, a warm-up
// mask, a saturating event counter and a threshold-triggered interrupt.
//
// Parameters:
//   N_CELLS  number of sensor cells (1..32)
//   CNT_W    width of event counter and threshold
//   WARMUP   cycles after arming during which raw alarms are ignored (>=1)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         sensing enable (level)
//   clr        single-cycle pulse: clears flags, counter, irq; restarts warm-up
//   thresh     event count that raises irq (0 treated as 1)
//   inj        self-test fault-injection select (used only with
//              EMSENSOR_SELFTEST_EN defined)
//   alarm_vec  sticky per-cell alarm flags
//   alarm_any  OR of alarm_vec
//   alarm_cnt  saturating count of cycles with any qualified raw alarm
//   irq        set when alarm_cnt reaches thresh, held until clr
//   state      FSM state: 0 IDLE, 1 ARM, 2 MONITOR, 3 ALARM
// Optional feature macro: EMSENSOR_SELFTEST_EN
module emsensor_array #(
    parameter int N_CELLS = 8,
    parameter int CNT_W   = 16,
    parameter int WARMUP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [CNT_W-1:0]   thresh,
    input  logic [N_CELLS-1:0] inj,
    output logic [N_CELLS-1:0] alarm_vec,
    output logic               alarm_any,
    output logic [CNT_W-1:0]   alarm_cnt,
    output logic               irq,
    output logic [1:0]         state
);

    localparam int WU_W = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MONITOR = 2'd2,
        ST_ALARM   = 2'd3
    } state_t;

    state_t             cur_st, nxt_st;
    logic [WU_W-1:0]    wu_q, wu_d;
    logic [N_CELLS-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;

    // Sensor cell flops: toggle, main and complementary shadow
    logic [N_CELLS-1:0] t_q, m_q, s_q;
    logic [N_CELLS-1:0] s_d;
    logic [N_CELLS-1:0] raw, qual;
    logic               hold;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   thresh_eff;

`ifdef EMSENSOR_SELFTEST_EN
    // Injected cells capture t instead of ~t so main == shadow next cycle
    assign s_d = ~(t_q ^ inj);
`else
    logic unused_inj;
    assign unused_inj = ^inj;
    assign s_d        = ~t_q;
`endif

    assign hold = (cur_st == ST_IDLE) || !en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= '0;
            m_q <= '0;
            s_q <= '1;
        end else if (hold) begin
            t_q <= '0;
            m_q <= '0;
            s_q <= '1;
        end else begin
            t_q <= ~t_q;
            m_q <= t_q;
            s_q <= s_d;
        end
    end

    assign raw  = ~(m_q ^ s_q);
    assign qual = ((cur_st == ST_MONITOR) || (cur_st == ST_ALARM)) ? raw : '0;

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign thresh_eff = (thresh == '0) ? CNT_W'(1) : thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st <= ST_IDLE;
            wu_q   <= '0;
            vec_q  <= '0;
            cnt_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            cur_st <= nxt_st;
            wu_q   <= wu_d;
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
        end
    end

    // clr has priority over everything, then en=0, then per-state behaviour
    always_comb begin
        nxt_st = cur_st;
        wu_d   = wu_q;
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        irq_d  = irq_q;
        if (clr) begin
            vec_d = '0;
            cnt_d = '0;
            irq_d = 1'b0;
            if (en) begin
                nxt_st = ST_ARM;
                wu_d   = WU_W'(WARMUP);
            end else begin
                nxt_st = ST_IDLE;
            end
        end else if (!en) begin
            nxt_st = ST_IDLE;
        end else begin
            case (cur_st)
                ST_IDLE: begin
                    nxt_st = ST_ARM;
                    wu_d   = WU_W'(WARMUP);
                end
                ST_ARM: begin
                    wu_d = wu_q - WU_W'(1);
                    if (wu_q <= WU_W'(1)) nxt_st = ST_MONITOR;
                end
                ST_MONITOR: begin
                    if (|qual) begin
                        vec_d = vec_q | qual;
                        cnt_d = cnt_inc;
                        if (cnt_inc >= thresh_eff) begin
                            nxt_st = ST_ALARM;
                            irq_d  = 1'b1;
                        end
                    end
                end
                ST_ALARM: begin
                    if (|qual) begin
                        vec_d = vec_q | qual;
                        cnt_d = cnt_inc;
                    end
                end
                default: nxt_st = ST_IDLE;
            endcase
        end
    end

    assign alarm_vec = vec_q;
    assign alarm_any = |vec_q;
    assign alarm_cnt = cnt_q;
    assign irq       = irq_q;
    assign state     = cur_st;

endmodule

// File: tb/tb_emsensor_array.sv
module tb_emsensor_array;

`ifdef EMSENSOR_SELFTEST_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clr;
    logic [15:0] thr;
    logic [7:0]  inj;
    logic [7:0]  alarm_vec;
    logic        alarm_any;
    logic [15:0] alarm_cnt;
    logic        irq;
    logic [1:0]  state;

    logic        en4, clr4;
    logic [3:0]  thr4;
    logic [7:0]  inj4;
    logic [7:0]  alarm_vec4;
    logic        alarm_any4;
    logic [3:0]  alarm_cnt4;
    logic        irq4;
    logic [1:0]  state4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    emsensor_array #(.N_CELLS(8), .CNT_W(16), .WARMUP(2)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .thresh(thr), .inj(inj),
        .alarm_vec(alarm_vec), .alarm_any(alarm_any), .alarm_cnt(alarm_cnt),
        .irq(irq), .state(state)
    );

    emsensor_array #(.N_CELLS(8), .CNT_W(4), .WARMUP(2)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .clr(clr4), .thresh(thr4), .inj(inj4),
        .alarm_vec(alarm_vec4), .alarm_any(alarm_any4), .alarm_cnt(alarm_cnt4),
        .irq(irq4), .state(state4)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic [7:0]  inj;
        logic [15:0] thr;
        logic [1:0]  e_st;
        logic [7:0]  e_vec;
        logic [15:0] e_cnt;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic c, input logic [7:0] i,
                       input logic [15:0] t, input logic [1:0] s,
                       input logic [7:0] v, input logic [15:0] n, input logic q);
        vec_t r;
        r.en = e; r.clr = c; r.inj = i; r.thr = t;
        r.e_st = s; r.e_vec = v; r.e_cnt = n; r.e_irq = q;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Expectations are for the self-test build; without self-test no
        // alarm can fire, so ALARM maps to MONITOR and alarm outputs stay 0.
        //  en clr inj    thr  state vec    cnt irq
        add(1, 0, 8'h00, 3, 1, 8'h00, 0, 0);   // v0  arm
        add(1, 0, 8'h00, 3, 1, 8'h00, 0, 0);   // v1
        add(1, 0, 8'h00, 3, 2, 8'h00, 0, 0);   // v2  monitor
        add(1, 0, 8'h20, 3, 2, 8'h00, 0, 0);   // v3  inj[5]
        add(1, 0, 8'h20, 3, 2, 8'h20, 1, 0);   // v4
        add(1, 0, 8'h20, 3, 2, 8'h20, 2, 0);   // v5
        add(1, 0, 8'h00, 3, 3, 8'h20, 3, 1);   // v6  third event -> alarm
        add(1, 0, 8'h00, 3, 3, 8'h20, 3, 1);   // v7
        add(1, 1, 8'h00, 3, 1, 8'h00, 0, 0);   // v8  clr -> arm
        add(1, 0, 8'h00, 3, 1, 8'h00, 0, 0);   // v9
        add(1, 0, 8'h00, 3, 2, 8'h00, 0, 0);   // v10
        add(1, 0, 8'hFF, 3, 2, 8'h00, 0, 0);   // v11 all cells one cycle
        add(1, 0, 8'h00, 3, 2, 8'hFF, 1, 0);   // v12 count 1 not 8
        add(1, 0, 8'h00, 3, 2, 8'hFF, 1, 0);   // v13
        add(1, 0, 8'h00, 1, 2, 8'hFF, 1, 0);   // v14 lower thresh: no irq yet
        add(1, 0, 8'h01, 1, 2, 8'hFF, 1, 0);   // v15
        add(1, 0, 8'h00, 1, 3, 8'hFF, 2, 1);   // v16 next event -> alarm
        add(0, 0, 8'h00, 1, 0, 8'hFF, 2, 1);   // v17 en=0: idle, retained
        add(0, 0, 8'h00, 1, 0, 8'hFF, 2, 1);   // v18
        add(1, 1, 8'h00, 3, 1, 8'h00, 0, 0);   // v19 clr with en from idle
        add(1, 0, 8'h04, 3, 1, 8'h00, 0, 0);   // v20 inj during arm
        add(1, 0, 8'h00, 3, 2, 8'h00, 0, 0);   // v21 ignored
        add(1, 0, 8'h08, 3, 2, 8'h00, 0, 0);   // v22
        add(1, 1, 8'h00, 3, 1, 8'h00, 0, 0);   // v23 clr beats raw alarm
        add(1, 0, 8'h00, 3, 1, 8'h00, 0, 0);   // v24
        add(1, 0, 8'h00, 3, 2, 8'h00, 0, 0);   // v25
        add(1, 0, 8'h10, 3, 2, 8'h00, 0, 0);   // v26
        add(1, 0, 8'h00, 3, 2, 8'h10, 1, 0);   // v27
        add(0, 1, 8'h00, 3, 0, 8'h00, 0, 0);   // v28 clr + en=0 -> idle

        rst = 1'b1; en = 1'b0; clr = 1'b0; thr = '0; inj = '0;
        en4 = 1'b0; clr4 = 1'b0; thr4 = '0; inj4 = '0;
        repeat (2) @(negedge clk);
        chk("rst state", 32'(state), 0);
        chk("rst vec",   32'(alarm_vec), 0);
        chk("rst any",   32'(alarm_any), 0);
        chk("rst cnt",   32'(alarm_cnt), 0);
        chk("rst irq",   32'(irq), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle state", 32'(state), 0);

        foreach (tbl[i]) begin
            logic [1:0]  es;
            logic [7:0]  ev;
            logic [15:0] ec;
            logic        eq;
            en = tbl[i].en; clr = tbl[i].clr; inj = tbl[i].inj; thr = tbl[i].thr;
            @(negedge clk);
            es = ST ? tbl[i].e_st  : ((tbl[i].e_st == 2'd3) ? 2'd2 : tbl[i].e_st);
            ev = ST ? tbl[i].e_vec : 8'h00;
            ec = ST ? tbl[i].e_cnt : 16'h0000;
            eq = ST ? tbl[i].e_irq : 1'b0;
            chk($sformatf("v%0d state", i), 32'(state), 32'(es));
            chk($sformatf("v%0d vec", i),   32'(alarm_vec), 32'(ev));
            chk($sformatf("v%0d any", i),   32'(alarm_any), 32'(|ev));
            chk($sformatf("v%0d cnt", i),   32'(alarm_cnt), 32'(ec));
            chk($sformatf("v%0d irq", i),   32'(irq), 32'(eq));
        end

        // Long quiet run in MONITOR, then asynchronous reset mid-operation
        en = 1'b1; clr = 1'b0; inj = '0; thr = 16'd100;
        @(negedge clk);
        chk("rearm state", 32'(state), 1);
        repeat (2) @(negedge clk);
        chk("mon state", 32'(state), 2);
        inj = 8'h02;
        @(negedge clk);
        inj = 8'h00;
        @(negedge clk);
        chk("mon cnt", 32'(alarm_cnt), ST ? 1 : 0);
        chk("mon vec", 32'(alarm_vec), ST ? 32'h02 : 0);
        repeat (100) @(negedge clk);
        chk("quiet state", 32'(state), 2);
        chk("quiet cnt",   32'(alarm_cnt), ST ? 1 : 0);
        chk("quiet irq",   32'(irq), 0);
        #2 rst = 1'b1;
        #1;
        chk("async state", 32'(state), 0);
        chk("async vec",   32'(alarm_vec), 0);
        chk("async any",   32'(alarm_any), 0);
        chk("async cnt",   32'(alarm_cnt), 0);
        chk("async irq",   32'(irq), 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        // Narrow counter: thresh 0 acts as 1, continuous injection saturates
        en4 = 1'b1; thr4 = 4'd0;
        repeat (3) @(negedge clk);
        chk("c4 mon state", 32'(state4), 2);
        inj4 = 8'h01;
        repeat (2) @(negedge clk);
        chk("c4 first cnt",   32'(alarm_cnt4), ST ? 1 : 0);
        chk("c4 first irq",   32'(irq4), ST ? 1 : 0);
        chk("c4 first state", 32'(state4), ST ? 3 : 2);
        repeat (9) @(negedge clk);
        chk("c4 mid cnt", 32'(alarm_cnt4), ST ? 10 : 0);
        repeat (16) @(negedge clk);
        chk("c4 sat cnt",   32'(alarm_cnt4), ST ? 15 : 0);
        chk("c4 sat irq",   32'(irq4), ST ? 1 : 0);
        chk("c4 sat vec",   32'(alarm_vec4), ST ? 32'h01 : 0);
        chk("c4 sat state", 32'(state4), ST ? 3 : 2);
        inj4 = 8'h00; en4 = 1'b0;
        @(negedge clk);
        chk("c4 off state", 32'(state4), 0);
        chk("c4 off cnt",   32'(alarm_cnt4), ST ? 15 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
